// File: rtl/serial_parity_rx.sv
// Serial front end for the even-parity checker: deserialises start / DATA_W data (LSB first) /
// even parity / stop frames and flags parity and framing errors with a one-cycle valid strobe.
module serial_parity_rx #(
    parameter int unsigned DATA_W       = 3,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              pb_out,
    output logic              valid,
    output logic              par_err,
    output logic              frm_err,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DATA_W + 1);

    localparam logic [CntW-1:0] CntMid  = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntEnd  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e            state_q;
    logic              rx_meta_q;
    logic              rx_s_q;
    logic [CntW-1:0]   cnt_q;
    logic [IdxW-1:0]   idx_q;
    logic [DATA_W-1:0] sh_q;
    logic              pbit_q;
    logic [DATA_W-1:0] data_q;
    logic              pb_q;
    logic              valid_q;
    logic              par_err_q;
    logic              frm_err_q;

    // New bit enters at the MSB so the first data bit ends up in bit 0.
    logic [DATA_W-1:0] sh_next;
    always_comb begin
        sh_next             = sh_q >> 1;
        sh_next[DATA_W-1]   = rx_s_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
            pbit_q    <= 1'b0;
            data_q    <= '0;
            pb_q      <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
            valid_q   <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end

                // Re-check the line half a bit in; a high level here was a glitch.
                StStart: begin
                    if (cnt_q == CntMid) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rx_s_q ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StData: begin
                    if (cnt_q == CntEnd) begin
                        cnt_q <= '0;
                        sh_q  <= sh_next;
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == IdxLast) begin
                            state_q <= StParity;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StParity: begin
                    if (cnt_q == CntEnd) begin
                        cnt_q   <= '0;
                        pbit_q  <= rx_s_q;
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StStop: begin
                    if (cnt_q == CntEnd) begin
                        cnt_q     <= '0;
                        valid_q   <= 1'b1;
                        data_q    <= sh_q;
                        pb_q      <= pbit_q;
                        par_err_q <= ^{sh_q, pbit_q};
                        frm_err_q <= ~rx_s_q;
                        state_q   <= rx_s_q ? StIdle : StBreak;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // Line stuck low after a bad stop bit: no start detection until it recovers.
                StBreak: begin
                    if (rx_s_q) begin
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_out = data_q;
    assign pb_out   = pb_q;
    assign valid    = valid_q;
    assign par_err  = par_err_q;
    assign frm_err  = frm_err_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: directed table, corner sequences and random frames checked
// against a frame-level parity/framing model.
module tb_serial_parity_rx;

    localparam int DW_A  = 3;
    localparam int CPB_A = 4;
    localparam int DW_B  = 8;
    localparam int CPB_B = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rx_a, rx_b;
    logic [DW_A-1:0] data_a;
    logic [DW_B-1:0] data_b;
    logic            pb_a, valid_a, par_a, frm_a, busy_a;
    logic            pb_b, valid_b, par_b, frm_b, busy_b;

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(DW_A), .CLKS_PER_BIT(CPB_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_a), .data_out(data_a), .pb_out(pb_a),
        .valid(valid_a), .par_err(par_a), .frm_err(frm_a), .busy(busy_a)
    );

    serial_parity_rx #(.DATA_W(DW_B), .CLKS_PER_BIT(CPB_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_b), .data_out(data_b), .pb_out(pb_b),
        .valid(valid_b), .par_err(par_b), .frm_err(frm_b), .busy(busy_b)
    );

    typedef struct {
        logic [7:0] data;
        logic       pb;
        logic       par;
        logic       frm;
        int         cyc;
    } rec_t;

    typedef struct {
        logic [7:0] data;
        logic       pb;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_pb;
        logic       exp_par;
        logic       exp_frm;
    } vec_t;

    rec_t q_a[$];
    rec_t q_b[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   fall_a = 0;
    int   fall_b = 0;
    logic prev_va = 1'b0;
    logic prev_vb = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [7:0] d, input logic p, input logic pe,
                                input logic fe, input int c);
        rec_t r;
        r.data = d;
        r.pb   = p;
        r.par  = pe;
        r.frm  = fe;
        r.cyc  = c;
        return r;
    endfunction

    // Record every valid strobe; a strobe seen on two consecutive cycles is an error.
    always @(negedge clk) begin
        if (valid_a === 1'b1) begin
            chk("valid_a_single_cycle", 32'(prev_va), 32'd0);
            q_a.push_back(mk({5'b0, data_a}, pb_a, par_a, frm_a, cyc));
        end
        if (valid_b === 1'b1) begin
            chk("valid_b_single_cycle", 32'(prev_vb), 32'd0);
            q_b.push_back(mk(data_b, pb_b, par_b, frm_b, cyc));
        end
        prev_va <= valid_a;
        prev_vb <= valid_b;
    end

    task automatic drive(input bit b, input logic v, input int n);
        if (b) rx_b = v;
        else   rx_a = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit b, input logic [7:0] data, input logic pb, input logic stop);
        int nd  = b ? DW_B : DW_A;
        int cpb = b ? CPB_B : CPB_A;
        if (b) fall_b = cyc;
        else   fall_a = cyc;
        drive(b, 1'b0, cpb);
        for (int i = 0; i < nd; i++) drive(b, data[i], cpb);
        drive(b, pb, cpb);
        drive(b, stop, cpb);
    endtask

    task automatic expect_frame(input bit b, input string tag, input logic [7:0] ed,
                                input logic ep, input logic epar, input logic efrm,
                                input bit chk_lat);
        int   waited = 0;
        int   nd  = b ? DW_B : DW_A;
        int   cpb = b ? CPB_B : CPB_A;
        int   lat;
        int   lref;
        rec_t r;
        while ((b ? q_b.size() : q_a.size()) == 0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if ((b ? q_b.size() : q_a.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_valid: got no valid pulse expected one", tag);
            return;
        end
        r = b ? q_b.pop_front() : q_a.pop_front();
        chk({tag, "_data"}, 32'(r.data), 32'(ed));
        chk({tag, "_pb"}, 32'(r.pb), 32'(ep));
        chk({tag, "_par_err"}, 32'(r.par), 32'(epar));
        chk({tag, "_frm_err"}, 32'(r.frm), 32'(efrm));
        if (chk_lat) begin
            lat  = r.cyc - (b ? fall_b : fall_a);
            lref = 2 + cpb / 2 + (nd + 2) * cpb;
            checks++;
            if (lat < lref - 1 || lat > lref + 1) begin
                errors++;
                $display("FAIL %s_latency: got %0d expected %0d +-1", tag, lat, lref);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        int   bc;
        logic [7:0] d;
        logic p, s;

        vt[0] = '{8'b101, 1'b0, 1'b1, 8'b101, 1'b0, 1'b0, 1'b0};
        vt[1] = '{8'b100, 1'b0, 1'b1, 8'b100, 1'b0, 1'b1, 1'b0};
        vt[2] = '{8'b011, 1'b0, 1'b0, 8'b011, 1'b0, 1'b0, 1'b1};
        vt[3] = '{8'b111, 1'b1, 1'b1, 8'b111, 1'b1, 1'b0, 1'b0};
        vt[4] = '{8'b010, 1'b1, 1'b1, 8'b010, 1'b1, 1'b0, 1'b0};
        vt[5] = '{8'b110, 1'b1, 1'b1, 8'b110, 1'b1, 1'b1, 1'b0};
        vt[6] = '{8'b000, 1'b1, 1'b0, 8'b000, 1'b1, 1'b1, 1'b1};

        rx_a  = 1'b1;
        rx_b  = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data_a", 32'(data_a), 32'd0);
        chk("reset_pb_a", 32'(pb_a), 32'd0);
        chk("reset_valid_a", 32'(valid_a), 32'd0);
        chk("reset_par_a", 32'(par_a), 32'd0);
        chk("reset_frm_a", 32'(frm_a), 32'd0);
        chk("reset_busy_a", 32'(busy_a), 32'd0);
        chk("reset_data_b", 32'(data_b), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send(0, vt[i].data, vt[i].pb, vt[i].stop);
            expect_frame(0, $sformatf("vec%0d", i), vt[i].exp_data, vt[i].exp_pb,
                         vt[i].exp_par, vt[i].exp_frm, i == 0);
            if (!vt[i].stop) begin
                // Line stays low: receiver must sit in the break state without framing anew.
                drive(0, 1'b0, 20);
                chk($sformatf("vec%0d_break_busy", i), 32'(busy_a), 32'd1);
                chk($sformatf("vec%0d_break_no_valid", i), 32'(q_a.size()), 32'd0);
            end
            drive(0, 1'b1, 2 * CPB_A);
        end

        // One-clock glitch on an idle line.
        bc = 0;
        drive(0, 1'b0, 1);
        rx_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bc += int'(busy_a);
        end
        chk("glitch_busy_1_to_3", 32'(bc >= 1 && bc <= 3), 32'd1);
        chk("glitch_no_valid", 32'(q_a.size()), 32'd0);

        // Back-to-back frames with no idle gap.
        send(0, 8'b111, 1'b1, 1'b1);
        send(0, 8'b010, 1'b1, 1'b1);
        rx_a = 1'b1;
        expect_frame(0, "b2b_first", 8'b111, 1'b1, 1'b0, 1'b0, 0);
        expect_frame(0, "b2b_second", 8'b010, 1'b1, 1'b0, 1'b0, 0);
        drive(0, 1'b1, 2 * CPB_A);

        // Reset mid-frame, during data bit 1.
        drive(0, 1'b0, CPB_A);
        drive(0, 1'b1, CPB_A);
        drive(0, 1'b0, CPB_A / 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_data", 32'(data_a), 32'd0);
        chk("midrst_pb", 32'(pb_a), 32'd0);
        chk("midrst_par", 32'(par_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        rx_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 2 * CPB_A);
        chk("midrst_no_valid", 32'(q_a.size()), 32'd0);
        send(0, 8'b110, 1'b1, 1'b1);
        expect_frame(0, "after_rst", 8'b110, 1'b1, 1'b1, 1'b0, 0);
        drive(0, 1'b1, 2 * CPB_A);

        // Random frames against the frame-level model.
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 7));
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) != 0);
            send(0, d, p, s);
            expect_frame(0, $sformatf("rnd%0d", i), d, p,
                         1'(($countones(d) + int'(p)) % 2), ~s, 0);
            if (!s) drive(0, 1'b0, $urandom_range(1, 8));
            drive(0, 1'b1, $urandom_range(1, 3));
        end

        // Wide instance.
        send(1, 8'hA5, 1'b0, 1'b1);
        rx_b = 1'b1;
        expect_frame(1, "wide_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1);
        drive(1, 1'b1, 2 * CPB_B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
